// File: rtl/dcmac_rx_merge.sv
// dcmac_rx_merge: pops four DCMAC segment lanes in rotation and packs up to four segments
// per 512-bit AXI-Stream beat, ending each beat at a packet boundary. Optional SOP framing via DCMAC_MERGE_SOP_CHECK_EN.
module dcmac_rx_merge #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [127:0]         seg0_tdata,
   input  logic [15:0]          seg0_tkeep,
   input  logic [2:0]           seg0_tuser,
   input  logic                 seg0_tlast,
   input  logic                 seg0_tvalid,
   output logic                 seg0_tready,
   input  logic [127:0]         seg1_tdata,
   input  logic [15:0]          seg1_tkeep,
   input  logic [2:0]           seg1_tuser,
   input  logic                 seg1_tlast,
   input  logic                 seg1_tvalid,
   output logic                 seg1_tready,
   input  logic [127:0]         seg2_tdata,
   input  logic [15:0]          seg2_tkeep,
   input  logic [2:0]           seg2_tuser,
   input  logic                 seg2_tlast,
   input  logic                 seg2_tvalid,
   output logic                 seg2_tready,
   input  logic [127:0]         seg3_tdata,
   input  logic [15:0]          seg3_tkeep,
   input  logic [2:0]           seg3_tuser,
   input  logic                 seg3_tlast,
   input  logic                 seg3_tvalid,
   output logic                 seg3_tready,
   output logic [511:0]         m_axis_tdata,
   output logic [63:0]          m_axis_tkeep,
   output logic                 m_axis_tuser,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [CNT_WIDTH-1:0] pkt_count,
   output logic [15:0]          drop_count
);

   localparam int unsigned LANES   = 4;
   localparam int unsigned SEG_W   = 128;
   localparam int unsigned KEEP_W  = 16;
   localparam int unsigned BEAT_W  = SEG_W * LANES;
   localparam int unsigned BKEEP_W = KEEP_W * LANES;
   localparam int unsigned DROP_W  = 16;
   localparam int unsigned ERR_BIT = 2;
   localparam int unsigned SOP_BIT = 1;
   localparam int unsigned ENA_BIT = 0;

   // Lane-indexed views of the four segment ports
   logic [SEG_W-1:0]   w_lane_data [LANES];
   logic [KEEP_W-1:0]  w_lane_keep [LANES];
   logic [LANES-1:0]   w_lane_err;
   logic [LANES-1:0]   w_lane_sop;
   logic [LANES-1:0]   w_lane_ena;
   logic [LANES-1:0]   w_lane_last;
   logic [LANES-1:0]   w_lane_valid;
   logic [LANES-1:0]   w_lane_ready;

   assign w_lane_data[0] = seg0_tdata;
   assign w_lane_data[1] = seg1_tdata;
   assign w_lane_data[2] = seg2_tdata;
   assign w_lane_data[3] = seg3_tdata;
   assign w_lane_keep[0] = seg0_tkeep;
   assign w_lane_keep[1] = seg1_tkeep;
   assign w_lane_keep[2] = seg2_tkeep;
   assign w_lane_keep[3] = seg3_tkeep;
   assign w_lane_err     = {seg3_tuser[ERR_BIT], seg2_tuser[ERR_BIT], seg1_tuser[ERR_BIT], seg0_tuser[ERR_BIT]};
   assign w_lane_sop     = {seg3_tuser[SOP_BIT], seg2_tuser[SOP_BIT], seg1_tuser[SOP_BIT], seg0_tuser[SOP_BIT]};
   assign w_lane_ena     = {seg3_tuser[ENA_BIT], seg2_tuser[ENA_BIT], seg1_tuser[ENA_BIT], seg0_tuser[ENA_BIT]};
   assign w_lane_last    = {seg3_tlast, seg2_tlast, seg1_tlast, seg0_tlast};
   assign w_lane_valid   = {seg3_tvalid, seg2_tvalid, seg1_tvalid, seg0_tvalid};

   assign seg0_tready = w_lane_ready[0];
   assign seg1_tready = w_lane_ready[1];
   assign seg2_tready = w_lane_ready[2];
   assign seg3_tready = w_lane_ready[3];

   logic [1:0]           r_ptr;
   logic                 r_err_acc;
   logic [BEAT_W-1:0]    r_m_tdata;
   logic [BKEEP_W-1:0]   r_m_tkeep;
   logic                 r_m_tuser;
   logic                 r_m_tlast;
   logic                 r_m_tvalid;
   logic [CNT_WIDTH-1:0] r_pkt_count;

   logic [1:0]           w_lane_idx [LANES];
   logic [SEG_W-1:0]     w_slot_data [LANES];
   logic [KEEP_W-1:0]    w_slot_keep [LANES];
   logic [LANES-1:0]     w_slot_err;
   logic [LANES-1:0]     w_slot_last;
   logic [LANES-1:0]     w_slot_valid;
   logic [LANES-1:0]     w_in_window;
   logic [2:0]           w_n;
   logic                 w_beat_last;
   logic                 w_all_valid;
   logic                 w_beat_err;
   logic                 w_out_free;
   logic                 w_drop;
   logic                 w_fire;
   logic                 w_emit;
   logic [BEAT_W-1:0]    w_beat_data;
   logic [BKEEP_W-1:0]   w_beat_keep;
   logic                 w_unused;

   // Rotate lanes into window slots starting at the lane pointer
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         w_lane_idx[i]   = r_ptr + 2'(i);
         w_slot_data[i]  = w_lane_data[w_lane_idx[i]];
         w_slot_keep[i]  = w_lane_keep[w_lane_idx[i]];
         w_slot_err[i]   = w_lane_err[w_lane_idx[i]];
         w_slot_last[i]  = w_lane_last[w_lane_idx[i]];
         w_slot_valid[i] = w_lane_valid[w_lane_idx[i]];
      end
   end

   // Beat length: up to and including the first slot carrying tlast
   always_comb begin
      w_n         = 3'd4;
      w_beat_last = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (!w_beat_last && w_slot_last[i]) begin
            w_n         = 3'(i + 1);
            w_beat_last = 1'b1;
         end
      end
   end

   always_comb begin
      w_in_window = '0;
      for (int i = 0; i < LANES; i++) begin
         w_in_window[i] = (3'(i) < w_n);
      end
   end

   assign w_all_valid = &(~w_in_window | w_slot_valid);
   assign w_beat_err  = |(w_in_window & w_slot_err);
   assign w_out_free  = !r_m_tvalid || m_axis_tready;
   // Discarded fires never touch the output register, so they skip the free check
   assign w_fire      = resetn && w_all_valid && (w_drop || w_out_free);
   assign w_emit      = w_fire && !w_drop;

   always_comb begin
      w_lane_ready = '0;
      for (int i = 0; i < LANES; i++) begin
         if (w_fire && w_in_window[i]) begin
            w_lane_ready[w_lane_idx[i]] = 1'b1;
         end
      end
   end

   always_comb begin
      w_beat_data = '0;
      w_beat_keep = '0;
      for (int i = 0; i < LANES; i++) begin
         if (w_in_window[i]) begin
            w_beat_data[SEG_W*i +: SEG_W]   = w_slot_data[i];
            w_beat_keep[KEEP_W*i +: KEEP_W] = w_slot_keep[i];
         end
      end
   end

   // Output register, lane pointer, error accumulator and packet counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ptr       <= '0;
         r_err_acc   <= 1'b0;
         r_m_tdata   <= '0;
         r_m_tkeep   <= '0;
         r_m_tuser   <= 1'b0;
         r_m_tlast   <= 1'b0;
         r_m_tvalid  <= 1'b0;
         r_pkt_count <= '0;
      end else begin
         if (w_emit) begin
            r_m_tdata  <= w_beat_data;
            r_m_tkeep  <= w_beat_keep;
            r_m_tuser  <= w_beat_last && (r_err_acc || w_beat_err);
            r_m_tlast  <= w_beat_last;
            r_m_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
         end
         if (w_fire) begin
            r_ptr     <= r_ptr + 2'(w_n);
            r_err_acc <= w_beat_last ? 1'b0 : (r_err_acc || w_beat_err);
         end
         if (r_m_tvalid && m_axis_tready && r_m_tlast) begin
            r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
         end
      end
   end

`ifdef DCMAC_MERGE_SOP_CHECK_EN
   typedef enum logic [1:0] {
      EXPECT_SOP = 2'd0,
      IN_PKT     = 2'd1,
      DISCARD    = 2'd2
   } state_t;

   state_t            r_state;
   logic [DROP_W-1:0] r_drop_count;
   logic              w_slot0_sop;

   assign w_slot0_sop = w_lane_sop[r_ptr];
   assign w_drop      = (r_state == DISCARD) || ((r_state == EXPECT_SOP) && !w_slot0_sop);
   assign drop_count  = r_drop_count;
   assign w_unused    = ^w_lane_ena;

   // Framing: a packet must open with sop in slot 0, otherwise it is popped and dropped
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= EXPECT_SOP;
         r_drop_count <= '0;
      end else if (w_fire) begin
         case (r_state)
            EXPECT_SOP: begin
               if (!w_slot0_sop) begin
                  if (r_drop_count != '1) begin
                     r_drop_count <= r_drop_count + DROP_W'(1);
                  end
                  if (!w_beat_last) begin
                     r_state <= DISCARD;
                  end
               end else if (!w_beat_last) begin
                  r_state <= IN_PKT;
               end
            end
            IN_PKT: begin
               if (w_beat_last) begin
                  r_state <= EXPECT_SOP;
               end
            end
            DISCARD: begin
               if (w_beat_last) begin
                  r_state <= EXPECT_SOP;
               end
            end
            default: r_state <= EXPECT_SOP;
         endcase
      end
   end
`else
   assign w_drop     = 1'b0;
   assign drop_count = '0;
   assign w_unused   = ^{w_lane_ena, w_lane_sop};
`endif

   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tkeep  = r_m_tkeep;
   assign m_axis_tuser  = r_m_tuser;
   assign m_axis_tlast  = r_m_tlast;
   assign m_axis_tvalid = r_m_tvalid;
   assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_dcmac_rx_merge.sv
// Bench for dcmac_rx_merge: packets are split into segments dealt round-robin to lanes; expected
// beats are each packet chunked into groups of four segments.
module tb_dcmac_rx_merge;

   typedef struct packed {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         err;
      logic         sop;
      logic         last;
   } seg_t;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         user;
      logic         last;
   } beat_t;

   logic         clk = 1'b0;
   logic         resetn;
   logic [127:0] seg_tdata  [4];
   logic [15:0]  seg_tkeep  [4];
   logic [2:0]   seg_tuser  [4];
   logic [3:0]   seg_tlast;
   logic [3:0]   seg_tvalid;
   logic [3:0]   seg_tready;
   logic [511:0] m_tdata;
   logic [63:0]  m_tkeep;
   logic         m_tuser;
   logic         m_tlast;
   logic         m_tvalid;
   logic         m_tready;
   logic [31:0]  pkt_count;
   logic [15:0]  drop_count;

   always #5 clk = ~clk;

   dcmac_rx_merge #(.CNT_WIDTH(32)) dut (
      .clk(clk), .resetn(resetn),
      .seg0_tdata(seg_tdata[0]), .seg0_tkeep(seg_tkeep[0]), .seg0_tuser(seg_tuser[0]),
      .seg0_tlast(seg_tlast[0]), .seg0_tvalid(seg_tvalid[0]), .seg0_tready(seg_tready[0]),
      .seg1_tdata(seg_tdata[1]), .seg1_tkeep(seg_tkeep[1]), .seg1_tuser(seg_tuser[1]),
      .seg1_tlast(seg_tlast[1]), .seg1_tvalid(seg_tvalid[1]), .seg1_tready(seg_tready[1]),
      .seg2_tdata(seg_tdata[2]), .seg2_tkeep(seg_tkeep[2]), .seg2_tuser(seg_tuser[2]),
      .seg2_tlast(seg_tlast[2]), .seg2_tvalid(seg_tvalid[2]), .seg2_tready(seg_tready[2]),
      .seg3_tdata(seg_tdata[3]), .seg3_tkeep(seg_tkeep[3]), .seg3_tuser(seg_tuser[3]),
      .seg3_tlast(seg_tlast[3]), .seg3_tvalid(seg_tvalid[3]), .seg3_tready(seg_tready[3]),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
      .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .pkt_count(pkt_count), .drop_count(drop_count)
   );

   seg_t       stream [$];
   beat_t      exp_q  [$];
   int         head   [4];
   int         delay  [4];
   int         vprob, rprob, stall_cycles;
   int         checks, failures;
   int         exp_pkts, exp_drops;
   logic [3:0] last_tready;
   logic       stalled;
   beat_t      held;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive();
      seg_t s;
      for (int l = 0; l < 4; l++) begin
         if (head[l] < stream.size() && delay[l] == 0 && int'($urandom_range(99)) < vprob) begin
            s             = stream[head[l]];
            seg_tvalid[l] = 1'b1;
            seg_tdata[l]  = s.data;
            seg_tkeep[l]  = s.keep;
            seg_tuser[l]  = {s.err, s.sop, 1'b1};
            seg_tlast[l]  = s.last;
         end else begin
            seg_tvalid[l] = 1'b0;
            seg_tdata[l]  = {$urandom, $urandom, $urandom, $urandom};
            seg_tkeep[l]  = 16'($urandom);
            seg_tuser[l]  = 3'($urandom);
            seg_tlast[l]  = 1'($urandom);
         end
      end
      if (stall_cycles > 0) begin
         m_tready = 1'b0;
         stall_cycles--;
      end else begin
         m_tready = (int'($urandom_range(99)) < rprob);
      end
   endtask

   task automatic cycle();
      beat_t cur, e;
      @(negedge clk);
      cur         = {m_tdata, m_tkeep, m_tuser, m_tlast};
      last_tready = seg_tready;
      for (int l = 0; l < 4; l++) begin
         if (seg_tready[l]) chk("tready_needs_tvalid", seg_tvalid[l], 1);
      end
      if (stalled) begin
         chk("stall_valid", m_tvalid, 1);
         chk("stall_hold_data", cur.data, held.data);
         chk("stall_hold_ctl", {cur.keep, cur.user, cur.last}, {held.keep, held.user, held.last});
      end
      if (m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", m_tvalid, 0);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", cur.data, e.data);
            chk("beat_keep", cur.keep, e.keep);
            chk("beat_user", cur.user, e.user);
            chk("beat_last", cur.last, e.last);
         end
      end
      stalled = m_tvalid && !m_tready;
      held    = cur;
      @(posedge clk);
      #1;
      for (int l = 0; l < 4; l++) begin
         if (last_tready[l]) head[l] += 4;
         if (delay[l] > 0) delay[l]--;
      end
      drive();
   endtask

   function automatic int pending_lanes();
      int p = 0;
      for (int l = 0; l < 4; l++) if (head[l] < stream.size()) p++;
      return p;
   endfunction

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || pending_lanes() != 0) && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_timeout", exp_q.size() + pending_lanes(), 0);
   endtask

   // Model: each packet becomes ceil(nseg/4) beats of consecutive segments, slot = index mod 4
   task automatic add_packet(input int nseg, input int last_bytes, input int err_seg, input bit sop);
      seg_t  s;
      beat_t b;
      bit    perr, emit;
      perr = 1'b0;
      b    = '0;
`ifdef DCMAC_MERGE_SOP_CHECK_EN
      emit = sop;
      if (!sop) exp_drops++;
`else
      emit = 1'b1;
`endif
      if (emit) exp_pkts++;
      for (int i = 0; i < nseg; i++) begin
         s.data = {$urandom, $urandom, $urandom, $urandom};
         s.keep = (i == nseg - 1) ? (16'hFFFF >> (16 - last_bytes)) : 16'hFFFF;
         s.err  = (i == err_seg);
         s.sop  = sop && (i == 0);
         s.last = (i == nseg - 1);
         stream.push_back(s);
         perr = perr | s.err;
         b.data[128*(i%4) +: 128] = s.data;
         b.keep[16*(i%4) +: 16]   = s.keep;
         if ((i % 4) == 3 || s.last) begin
            b.last = s.last;
            b.user = s.last && perr;
            if (emit) exp_q.push_back(b);
            b = '0;
         end
      end
   endtask

   task automatic model_reset();
      stream.delete();
      exp_q.delete();
      head      = '{0, 1, 2, 3};
      delay     = '{0, 0, 0, 0};
      stalled   = 1'b0;
      exp_pkts  = 0;
      exp_drops = 0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_tvalid"}, m_tvalid, 0);
      chk({tag, "_tdata"}, m_tdata, 0);
      chk({tag, "_tkeep"}, m_tkeep, 0);
      chk({tag, "_tuser_tlast"}, {m_tuser, m_tlast}, 0);
      chk({tag, "_pkt_count"}, pkt_count, 0);
      chk({tag, "_drop_count"}, drop_count, 0);
      chk({tag, "_tready"}, seg_tready, 0);
   endtask

   initial begin
      checks = 0; failures = 0; stall_cycles = 0;
      vprob = 100; rprob = 100;
      model_reset();
      resetn = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      resetn = 1'b1;

      // Full 4-segment packet from lane 0
      add_packet(4, 16, -1, 1'b1);
      drain(50);
      chk("pkt_count_full", pkt_count, exp_pkts);

      // 2-seg packet moves ptr to 2; 3-seg packet wraps lanes 2,3,0; 1-seg packet on lane 1
      add_packet(2, 16, -1, 1'b1);
      add_packet(3, 8, -1, 1'b1);
      add_packet(1, 4, -1, 1'b1);
      drain(50);
      chk("pkt_count_wrap", pkt_count, exp_pkts);

      // 9-segment packet, error on segment 2, downstream stalled 3 cycles mid-stream
      add_packet(9, 10, 2, 1'b1);
      begin
         int n = 0;
         while (!m_tvalid && n < 20) begin cycle(); n++; end
         chk("stall_start_timeout", m_tvalid, 1);
      end
      stall_cycles = 3;
      drain(60);
      chk("pkt_count_stall", pkt_count, exp_pkts);

      // Randomised traffic with random valid gaps and backpressure
      vprob = 70; rprob = 70;
      for (int p = 0; p < 40; p++) begin
         add_packet(int'($urandom_range(1, 9)), int'($urandom_range(1, 16)),
                    int'($urandom_range(0, 15)), 1'b1);
      end
      drain(4000);
      chk("pkt_count_random", pkt_count, exp_pkts);

      // Packets without sop: dropped under the SOP check, emitted otherwise
      vprob = 100; rprob = 100;
      add_packet(3, 16, 1, 1'b0);
      add_packet(1, 5, 0, 1'b0);
      add_packet(2, 16, -1, 1'b1);
      drain(60);
      chk("drop_count_sop", drop_count, exp_drops);
      chk("pkt_count_sop", pkt_count, exp_pkts);

      // Reset pulsed mid-packet with lanes still valid
      add_packet(8, 16, -1, 1'b1);
      cycle();
      cycle();
      #3 resetn = 1'b0;
      #1;
      chk_idle_outputs("mid_reset");
      model_reset();
      drive();
      @(posedge clk);
      #1 resetn = 1'b1;

      // After reset the stream restarts at lane 0; lane 2 arrives 5 cycles late
      add_packet(4, 12, -1, 1'b1);
      delay[2] = 5;
      drive();
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("delay_no_ready", last_tready, 0);
      end
      cycle();
      chk("delay_single_fire", last_tready, 4'hF);
      drain(20);
      chk("pkt_count_after_reset", pkt_count, exp_pkts);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
